// File: rtl/oddeven_sorter_pkg.sv
// Shared types and default sizes for the odd-even transposition sorter.
package oddeven_sorter_pkg;

  localparam int DEF_W = 4;
  localparam int DEF_N = 8;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SORT   = 2'd1,
    ST_UNLOAD = 2'd2
  } state_e;

endpackage

// File: rtl/oddeven_sorter_if.sv
// Load/unload streams of the sorter; master is the producer/consumer side.
interface oddeven_sorter_if
  import oddeven_sorter_pkg::*;
#(
  parameter int W = DEF_W
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         sorting;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, sorting
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, sorting
  );
endinterface

// File: rtl/oddeven_sorter_cmp_swap.sv
// Combinational compare-swap cell: orders one adjacent pair, flags a swap.
module cmp_swap #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         swapped
);

  // Strict compare so equal words keep their positions.
  assign swapped = (a > b);
  assign lo      = swapped ? b : a;
  assign hi      = swapped ? a : b;

endmodule

// File: rtl/oddeven_sorter.sv
// Odd-even transposition sorter: load N words, sort ascending, stream out.
// Optional macro ODDEVEN_SORTER_EARLY_DONE_EN: leave SORT once an even and
// an odd phase in a row made no swap (N-phase limit still applies).
module oddeven_sorter
  import oddeven_sorter_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int N = DEF_N
) (
  input  logic               clk,
  input  logic               reset,
  oddeven_sorter_if.slave    bus
);

  localparam int IW = $clog2(N);
  localparam int PW = IW + 1;

  state_e        state;
  logic [IW-1:0] idx;
  logic [PW-1:0] phase;
  logic [W-1:0]  rows     [N];
  logic [W-1:0]  rows_nxt [N];
  logic [W-1:0]  lo_w     [N-1];
  logic [W-1:0]  hi_w     [N-1];
  logic [N-2:0]  sw_w;
  logic          swap_any;
  logic          last_idx;
  logic          last_phase;
  logic          sort_done;

  for (genvar i = 0; i < N - 1; i++) begin : g_cell
    cmp_swap #(.W(W)) u_cmp_swap (
      .a       (rows[i]),
      .b       (rows[i+1]),
      .lo      (lo_w[i]),
      .hi      (hi_w[i]),
      .swapped (sw_w[i])
    );
  end

  // Write back only the cells whose pair parity matches the current phase.
  always_comb begin
    rows_nxt = rows;
    swap_any = 1'b0;
    for (int i = 0; i < N - 1; i++) begin
      if (i[0] == phase[0]) begin
        rows_nxt[i]   = lo_w[i];
        rows_nxt[i+1] = hi_w[i];
        swap_any      = swap_any | sw_w[i];
      end
    end
  end

  assign last_idx   = (idx == IW'(N - 1));
  assign last_phase = (phase == PW'(N - 1));

`ifdef ODDEVEN_SORTER_EARLY_DONE_EN
  logic prev_sw;
  assign sort_done = last_phase || ((phase != '0) && !swap_any && !prev_sw);
`else
  // The swap result only matters for the early exit.
  logic unused_swap;
  assign unused_swap = swap_any;
  assign sort_done   = last_phase;
`endif

  // Load, sort and unload sequencing with row storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_LOAD;
      idx   <= '0;
      phase <= '0;
`ifdef ODDEVEN_SORTER_EARLY_DONE_EN
      prev_sw <= 1'b0;
`endif
      for (int i = 0; i < N; i++) rows[i] <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (bus.in_valid) begin
            rows[idx] <= bus.in_data;
            if (last_idx) begin
              idx   <= '0;
              phase <= '0;
`ifdef ODDEVEN_SORTER_EARLY_DONE_EN
              prev_sw <= 1'b0;
`endif
              state <= ST_SORT;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        ST_SORT: begin
          rows  <= rows_nxt;
          phase <= phase + PW'(1);
`ifdef ODDEVEN_SORTER_EARLY_DONE_EN
          prev_sw <= swap_any;
`endif
          if (sort_done) begin
            phase <= '0;
            state <= ST_UNLOAD;
          end
        end
        ST_UNLOAD: begin
          if (bus.out_ready) begin
            if (last_idx) begin
              idx   <= '0;
              state <= ST_LOAD;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_LOAD);
  assign bus.out_valid = (state == ST_UNLOAD);
  assign bus.sorting   = (state == ST_SORT);
  assign bus.out_data  = rows[idx];

endmodule

// File: tb/tb_oddeven_sorter.sv
// Randomized bench for oddeven_sorter with a queue-based reference model.
module tb_oddeven_sorter;
  import oddeven_sorter_pkg::*;

  localparam int W = DEF_W;
  localparam int N = DEF_N;

  logic clk;
  logic reset;

  oddeven_sorter_if #(.W(W)) bus ();

  oddeven_sorter #(.W(W), .N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: sorted block by insertion sort, SORT length from phase rules.
  function automatic void model_block(input int b[N], output int r[N], output int len);
`ifdef ODDEVEN_SORTER_EARLY_DONE_EN
    int a[N];
    bit sw[N];
    int t;
`endif
    int x;
    r = b;
    for (int i = 1; i < N; i++)
      for (int j = i; j > 0 && r[j-1] > r[j]; j--) begin
        x = r[j]; r[j] = r[j-1]; r[j-1] = x;
      end
    len = N;
`ifdef ODDEVEN_SORTER_EARLY_DONE_EN
    a = b;
    for (int p = 0; p < N; p++) begin
      sw[p] = 1'b0;
      for (int i = p % 2; i + 1 < N; i += 2)
        if (a[i] > a[i+1]) begin
          t = a[i]; a[i] = a[i+1]; a[i+1] = t; sw[p] = 1'b1;
        end
      if (p > 0 && !sw[p] && !sw[p-1]) begin
        len = p + 1;
        break;
      end
    end
`endif
  endfunction

  int in_q[$];
  int exp_q[$];
  int acc_q[$];
  int len_q[$];
  int cyc = 0;
  int out_cnt = 0;
  int blocks_done = 0;
  int sort_cnt = 0;
  bit first_seen = 0;
  bit prev_stall = 0;
  bit after_last = 0;
  logic [W-1:0] prev_data;
  bit rdy_random = 0;

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    int blk[N];
    int res[N];
    int len;
    cyc++;
    if (!reset) begin
      in_q.delete(); exp_q.delete(); acc_q.delete(); len_q.delete();
      out_cnt = 0; first_seen = 0; prev_stall = 0; after_last = 0; sort_cnt = 0;
    end else begin
      if (after_last) check("in_ready_after_unload", bus.in_ready, 1);
      after_last = 0;
      if (bus.sorting || bus.out_valid) check("in_ready_outside_load", bus.in_ready, 0);
      if (bus.sorting) sort_cnt++;
      if (bus.in_valid && bus.in_ready) begin
        in_q.push_back(int'(bus.in_data));
        if (in_q.size() == N) begin
          for (int i = 0; i < N; i++) blk[i] = in_q[i];
          model_block(blk, res, len);
          for (int i = 0; i < N; i++) exp_q.push_back(res[i]);
          acc_q.push_back(cyc);
          len_q.push_back(len);
          in_q.delete();
          sort_cnt = 0;
        end
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          if (!first_seen) begin
            check("latency", cyc - acc_q[0], len_q[0] + 1);
            check("sort_cycles", sort_cnt, len_q[0]);
            first_seen = 1;
          end
          if (prev_stall) check("stall_stable", bus.out_data, prev_data);
          check("out_data", bus.out_data, exp_q[0]);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            out_cnt++;
            if (out_cnt == N) begin
              out_cnt = 0;
              first_seen = 0;
              void'(acc_q.pop_front());
              void'(len_q.pop_front());
              blocks_done++;
              after_last = 1;
            end
          end
        end
        prev_stall = !bus.out_ready;
        prev_data  = bus.out_data;
      end else begin
        if (prev_stall) check("out_valid_dropped_in_stall", 0, 1);
        prev_stall = 0;
      end
    end
  end

  // Consumer: out_ready either held high or randomly gapped.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rdy_random ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  task automatic send_word(input int w);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = W'(w);
    do begin
      @(negedge clk);
      t++;
    end while (!bus.in_ready && t < 400);
    if (t >= 400) check("in_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_block(input int blk[N], input int gapmax);
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, gapmax)) begin
        @(posedge clk);
        #1;
      end
      send_word(blk[i]);
    end
  endtask

  task automatic wait_blocks(input int target, input int budget);
    int t;
    t = 0;
    while (blocks_done < target && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("blocks_drained", blocks_done, target);
  endtask

  task automatic check_cleared(input string tag);
    logic any;
    any = 1'b0;
    for (int k = 0; k < N; k++) any = any | (|dut.rows[k]);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_sorting"}, bus.sorting, 0);
    check({tag, "_out_data"}, bus.out_data, 0);
    check({tag, "_rows_zero"}, any, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time budget");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int pin_in[N]   = '{3, 0, 15, 0, 12, 0, 0, 0};
    int pin_exp[N]  = '{0, 0, 0, 0, 0, 3, 12, 15};
    int rev[N]      = '{15, 14, 13, 12, 11, 10, 9, 8};
    int asc[N]      = '{1, 2, 3, 4, 5, 6, 7, 8};
    int dup[N]      = '{5, 5, 5, 5, 2, 2, 2, 2};
    int dup_exp[N]  = '{2, 2, 2, 2, 5, 5, 5, 5};
    int blk[N];
    int res[N];
    int len;
    int target;
    int t;

    // Hand-computed pins on the reference model itself.
    model_block(pin_in, res, len);
    for (int i = 0; i < N; i++) check("model_pin_sort", res[i], pin_exp[i]);
`ifndef ODDEVEN_SORTER_EARLY_DONE_EN
    check("model_pin_len", len, 8);
`endif
    model_block(dup, res, len);
    for (int i = 0; i < N; i++) check("model_pin_dup", res[i], dup_exp[i]);
    model_block(rev, res, len);
    check("model_pin_rev_len", len, 8);
    model_block(asc, res, len);
`ifdef ODDEVEN_SORTER_EARLY_DONE_EN
    check("model_pin_asc_len", len, 2);
`else
    check("model_pin_asc_len", len, 8);
`endif

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    reset = 1'b0;
    #23;
    check_cleared("reset");
    @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    check_cleared("post_reset");

    target = 0;
    send_block(pin_in, 0);
    wait_blocks(++target, 200);
    send_block(rev, 1);
    wait_blocks(++target, 200);
    send_block(asc, 0);
    wait_blocks(++target, 200);
    send_block(dup, 2);
    wait_blocks(++target, 200);

    // Abort during SORT.
    send_block(rev, 0);
    t = 0;
    while (t < 3) begin
      @(negedge clk);
      if (bus.sorting) t++;
    end
    #2 reset = 1'b0;
    #2 check_cleared("abort_sort");
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    send_block(pin_in, 0);
    wait_blocks(++target, 200);

    // Abort after four outputs.
    send_block(dup, 0);
    t = 0;
    while (out_cnt < 4 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("reached_four_outputs", out_cnt, 4);
    reset = 1'b0;
    #2 check_cleared("abort_unload");
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    send_block(rev, 0);
    wait_blocks(++target, 200);

    // Random blocks with input and output gaps.
    rdy_random = 1;
    for (int b = 0; b < 100; b++) begin
      for (int i = 0; i < N; i++)
        blk[i] = (b % 3 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, (1 << W) - 1));
      send_block(blk, 3);
    end
    target += 100;
    wait_blocks(target, 2000);
    rdy_random = 0;

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
